// File: rtl/dose_countdown_timer_pkg.sv
// Shared definitions for the dose reminder countdown: command codes, BCD digit limits,
// FSM encoding and a single-digit BCD borrow helper.
package dose_countdown_timer_pkg;

  typedef logic [23:0] bcd_time_t;

  localparam logic [3:0] CMD_CLEAR = 4'd0;
  localparam logic [3:0] CMD_SET   = 4'd1;
  localparam logic [3:0] CMD_LOAD  = 4'd2;
  localparam logic [3:0] CMD_START = 4'd3;
  localparam logic [3:0] CMD_IDLE  = 4'd4;

  localparam logic [3:0] MAX_H10 = 4'd1;
  localparam logic [3:0] MAX_H1  = 4'd2;
  localparam logic [3:0] MAX_M10 = 4'd5;
  localparam logic [3:0] MAX_DEC = 4'd9;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOADED  = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  // Returns {borrow_out, digit}; a digit at zero wraps to 'wrap' and borrows onward.
  function automatic logic [4:0] dec_digit(input logic [3:0] d, input logic [3:0] wrap,
                                           input logic borrow);
    if (!borrow)
      return {1'b0, d};
    else if (d == 4'd0)
      return {1'b1, wrap};
    else
      return {1'b0, d - 4'd1};
  endfunction

endpackage

// File: rtl/dose_countdown_timer_bcd_time_decrement.sv
// Combinational hh:mm:ss BCD minus one second, with a zero detect on the input time.
module bcd_time_decrement
  import dose_countdown_timer_pkg::*;
(
  input  logic [23:0] time_in,
  output logic [23:0] time_out,
  output logic        is_zero
);

  logic [4:0] s1, s10, m1, m10, h1, h10;

  always_comb begin
    s1  = dec_digit(time_in[3:0],   MAX_DEC, 1'b1);
    s10 = dec_digit(time_in[7:4],   MAX_M10, s1[4]);
    m1  = dec_digit(time_in[11:8],  MAX_DEC, s10[4]);
    m10 = dec_digit(time_in[15:12], MAX_M10, m1[4]);
    // Hours are a plain two-digit decimal count: 10 -> 09, 12 -> 11.
    h1  = dec_digit(time_in[19:16], MAX_DEC, m10[4]);
    h10 = dec_digit(time_in[23:20], 4'd0,    h1[4]);
    is_zero  = (time_in == 24'h000000);
    time_out = is_zero ? 24'h000000
                       : {h10[3:0], h1[3:0], m10[3:0], m1[3:0], s10[3:0], s1[3:0]};
  end

endmodule

// File: rtl/dose_countdown_timer.sv
// Dose reminder countdown: loads a sanitised BCD preset, counts it down once per second
// while running, and flags expiry at 00:00:00.
module dose_countdown_timer
  import dose_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int TICK_W   = 26
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [3:0]  controlState,
  input  logic [23:0] presetBCD,
  output logic [23:0] timeBCD,
  output logic        running,
  output logic        expired,
  output logic        expiredPulse,
  output logic        secondTick
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [1:0]        state, next_state;
  logic [TICK_W-1:0] presc, next_presc;
  logic [23:0]       next_time, dec_time;
  logic              is_zero, tick_evt, exp_evt, do_count;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Clamping H1 to 2 unconditionally also caps 1x hours at 12.
  function automatic logic [23:0] sanitise(input logic [23:0] p);
    return {clamp_digit(p[23:20], MAX_H10), clamp_digit(p[19:16], MAX_H1),
            clamp_digit(p[15:12], MAX_M10), clamp_digit(p[11:8],  MAX_DEC),
            clamp_digit(p[7:4],   MAX_M10), clamp_digit(p[3:0],   MAX_DEC)};
  endfunction

  bcd_time_decrement u_dec (
    .time_in  (timeBCD),
    .time_out (dec_time),
    .is_zero  (is_zero)
  );

  always_comb begin
    next_state = state;
    next_time  = timeBCD;
    next_presc = presc;
    tick_evt   = 1'b0;
    exp_evt    = 1'b0;
    // Clear and set override counting in the same cycle.
    do_count   = (state == ST_RUN) && (controlState != CMD_CLEAR) && (controlState != CMD_SET);
    case (controlState)
      CMD_CLEAR: begin
        next_time  = 24'h000000;
        next_presc = '0;
        next_state = ST_IDLE;
      end
      CMD_SET: begin
        next_time  = sanitise(presetBCD);
        next_presc = '0;
        next_state = ST_LOADED;
      end
      CMD_START: begin
        if (state == ST_IDLE || state == ST_LOADED) begin
          if (is_zero) begin
            next_state = ST_EXPIRED;
            exp_evt    = 1'b1;
          end else begin
            next_state = ST_RUN;
            next_presc = '0;
          end
        end
      end
      default: ;
    endcase
    if (do_count) begin
      if (presc == TICK_LAST) begin
        next_presc = '0;
        tick_evt   = 1'b1;
        next_time  = dec_time;
        if (timeBCD == 24'h000001) begin
          next_state = ST_EXPIRED;
          exp_evt    = 1'b1;
        end
      end else begin
        next_presc = presc + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ST_IDLE;
      presc        <= '0;
      timeBCD      <= 24'h000000;
      running      <= 1'b0;
      expired      <= 1'b0;
      expiredPulse <= 1'b0;
      secondTick   <= 1'b0;
    end else begin
      state        <= next_state;
      presc        <= next_presc;
      timeBCD      <= next_time;
      running      <= (next_state == ST_RUN);
      expired      <= (next_state == ST_EXPIRED);
      expiredPulse <= exp_evt;
      secondTick   <= tick_evt;
    end
  end

endmodule

// File: tb/tb_dose_countdown_timer.sv
// Scoreboard bench for dose_countdown_timer with TICK_DIV=4: stimulus queues expected
// outputs per clock edge, a negedge monitor pops and compares them.
module tb_dose_countdown_timer;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [3:0]  controlState = 4'd4;
  logic [23:0] presetBCD = 24'h0;
  logic [23:0] timeBCD;
  logic        running, expired, expiredPulse, secondTick;

  typedef struct {
    int          cyc;
    logic [27:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  dose_countdown_timer #(.TICK_DIV(4), .TICK_W(3)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .controlState (controlState),
    .presetBCD    (presetBCD),
    .timeBCD      (timeBCD),
    .running      (running),
    .expired      (expired),
    .expiredPulse (expiredPulse),
    .secondTick   (secondTick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic [27:0] got;
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      got = {timeBCD, running, expired, expiredPulse, secondTick};
      checks++;
      if (e.cyc != cyc || got !== e.v) begin
        errors++;
        $display("FAIL %s cyc=%0d: got time=%h run=%b exp=%b pulse=%b tick=%b, expected time=%h run=%b exp=%b pulse=%b tick=%b",
                 e.nm, cyc, got[27:4], got[3], got[2], got[1], got[0],
                 e.v[27:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic step(input logic [3:0] c, input logic [23:0] t, input logic r,
                      input logic e, input logic ep, input logic st, input string nm);
    exp_t x;
    controlState = c;
    x.cyc = cyc + 1;
    x.v   = {t, r, e, ep, st};
    x.nm  = nm;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic check_now(input string nm, input logic [27:0 ] want);
    logic [27:0] got;
    got = {timeBCD, running, expired, expiredPulse, secondTick};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] t;
    #1 resetN = 1'b0;
    #2 check_now("reset_state", 28'h0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // Sanitising preset clamps every digit
    presetBCD = 24'h0F9F7A;
    step(4'd1, 24'h025959, 0, 0, 0, 0, "sanitise_0F9F7A");
    step(4'd4, 24'h025959, 0, 0, 0, 0, "loaded_hold");
    presetBCD = 24'h1FFFFF;
    step(4'd1, 24'h125959, 0, 0, 0, 0, "sanitise_max");

    // Three-second countdown to expiry
    presetBCD = 24'h000003;
    step(4'd1, 24'h000003, 0, 0, 0, 0, "load_3s");
    step(4'd3, 24'h000003, 1, 0, 0, 0, "start_3s");
    for (int k = 1; k <= 14; k++) begin
      t = (k < 4) ? 24'h000003 : (k < 8) ? 24'h000002 : (k < 12) ? 24'h000001 : 24'h000000;
      step(4'd4, t, k < 12, k >= 12, k == 12, (k % 4 == 0) && k <= 12, "count_3s");
    end

    // Hour borrows
    presetBCD = 24'h100000;
    step(4'd1, 24'h100000, 0, 1'b0, 0, 0, "load_10h");
    step(4'd3, 24'h100000, 1, 0, 0, 0, "start_10h");
    for (int k = 1; k <= 3; k++) step(4'd4, 24'h100000, 1, 0, 0, 0, "wait_10h");
    step(4'd4, 24'h095959, 1, 0, 0, 1, "borrow_10h");
    presetBCD = 24'h010000;
    step(4'd1, 24'h010000, 0, 0, 0, 0, "set_in_run");
    step(4'd3, 24'h010000, 1, 0, 0, 0, "start_1h");
    for (int k = 1; k <= 3; k++) step(4'd4, 24'h010000, 1, 0, 0, 0, "wait_1h");
    step(4'd4, 24'h005959, 1, 0, 0, 1, "borrow_1h");
    step(4'd0, 24'h000000, 0, 0, 0, 0, "clear_in_run");

    // Start with zero time expires immediately
    step(4'd3, 24'h000000, 0, 1, 1, 0, "start_zero");
    step(4'd4, 24'h000000, 0, 1, 0, 0, "expired_hold");
    step(4'd3, 24'h000000, 0, 1, 0, 0, "start_in_expired");
    step(4'd0, 24'h000000, 0, 0, 0, 0, "clear_expired");

    // Set wins over a same-cycle tick
    presetBCD = 24'h000010;
    step(4'd1, 24'h000010, 0, 0, 0, 0, "load_10s");
    step(4'd3, 24'h000010, 1, 0, 0, 0, "start_10s");
    for (int k = 1; k <= 3; k++) step(4'd4, 24'h000010, 1, 0, 0, 0, "wait_10s");
    presetBCD = 24'h000200;
    step(4'd1, 24'h000200, 0, 0, 0, 0, "set_over_tick");
    step(4'd4, 24'h000200, 0, 0, 0, 0, "no_count_loaded");
    step(4'd4, 24'h000200, 0, 0, 0, 0, "no_count_loaded2");

    // Asynchronous reset mid-run
    presetBCD = 24'h000005;
    step(4'd1, 24'h000005, 0, 0, 0, 0, "load_5s");
    step(4'd3, 24'h000005, 1, 0, 0, 0, "start_5s");
    step(4'd4, 24'h000005, 1, 0, 0, 0, "run_5s");
    step(4'd4, 24'h000005, 1, 0, 0, 0, "run_5s_b");
    #2 resetN = 1'b0;
    #1 check_now("async_reset", 28'h0);
    @(negedge clk);
    #1 resetN = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 6; k++) step(4'd4, 24'h000000, 0, 0, 0, 0, "after_reset_idle");
    presetBCD = 24'h000002;
    step(4'd1, 24'h000002, 0, 0, 0, 0, "reload_2s");
    step(4'd3, 24'h000002, 1, 0, 0, 0, "restart_2s");
    for (int k = 1; k <= 3; k++) step(4'd4, 24'h000002, 1, 0, 0, 0, "wait_2s");
    step(4'd4, 24'h000001, 1, 0, 0, 1, "tick_2s");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dose_countdown_timer.md
Name:
dose_countdown_timer

Overview:
- Consumer end of the control interface: takes the 4-bit state command and the 24-bit BCD hh:mm:ss preset from the control block.
- Counts the preset down once per second and raises an expiry alarm at 00:00:00, for the patient dose reminder.
- Drives the BCD time to the seven-segment display path and the alarm to the LED/buzzer path.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick; benches use 4.
- TICK_W, 26, width of the prescaler counter; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all state on rising edge.
- resetN  input  1  asynchronous active-low reset.
- controlState  input  4  command code: 0 clear, 1 set, 2 load-ID, 3 start, 4 idle/no button, 5-15 reserved.
- presetBCD  input  24  preset time, digits [23:20] H10, [19:16] H1, [15:12] M10, [11:8] M1, [7:4] S10, [3:0] S1.
- timeBCD  output  24  current remaining time, same digit layout.
- running  output  1  high while in RUN.
- expired  output  1  high while in EXPIRED.
- expiredPulse  output  1  one-cycle pulse on entry to EXPIRED.
- secondTick  output  1  one-cycle pulse on each prescaler wrap while in RUN.

Behaviour:
Reset:
- resetN low forces timeBCD=0, FSM=IDLE, prescaler=0, and all flags low, immediately and asynchronously.

States:
- IDLE, LOADED, RUN, EXPIRED.
- running=(RUN), expired=(EXPIRED); both are registered.

Commands (evaluated every cycle; 1 and 3 are level-sensitive, re-applied each cycle while held):
- Code 0, any state: timeBCD<=0, prescaler<=0, next state IDLE.
- Code 1, any state: timeBCD<=sanitised presetBCD, prescaler<=0, next state LOADED.
  - Sanitising clamps each digit to H10<=1, H1<=2, M10<=5, M1<=9, S10<=5, S1<=9.
  - If H10=1 and H1>2, hours become 12.
- Code 3, from IDLE/LOADED: if timeBCD==0, go to EXPIRED and pulse expiredPulse; otherwise go to RUN with prescaler<=0.
- Code 3, in RUN/EXPIRED: no effect.
- Codes 2, 4, 5-15: hold the current state. RUN keeps counting, because the control block returns code 4 when buttons are released.

Prescaler:
- In RUN, increments each cycle.
- On reaching TICK_DIV-1 it wraps to 0, secondTick=1, and timeBCD decrements by one second on the same edge.
- Halted outside RUN.
- First tick occurs TICK_DIV cycles after entering RUN.

BCD decrement (combinational from timeBCD, registered on tick):
- S1 0->9 with borrow into S10.
- S10 0->5 with borrow into M1.
- M1 0->9 with borrow into M10.
- M10 0->5 with borrow into the hours.
- Hours are a two-digit BCD decrement: 10->09, 01->00, 12->11.

Expiry:
- On the tick where timeBCD==00:00:01, timeBCD<=0, next state EXPIRED, expiredPulse=1 for exactly that cycle.
- EXPIRED holds timeBCD=0 and expired=1 until code 0 or 1.

Simultaneous events:
- Command 0/1 has priority over a same-cycle tick: no decrement, no expiredPulse.
- Reset mid-count aborts with no pulse.

Widths:
- No value ever exceeds 12:59:59.
- Hours 00 is legal; there is no 12-hour AM/PM wrap, because this is a countdown.

Decomposition:
- Shared package holds:
  - command codes CMD_CLEAR=4'd0, CMD_SET=4'd1, CMD_LOAD=4'd2, CMD_START=4'd3, CMD_IDLE=4'd4;
  - digit limits MAX_H10=1, MAX_H1=2, MAX_M10=5, MAX_DEC=9;
  - FSM state encoding.
- One natural sub-module, bcd_time_decrement: pure combinational 24-bit hh:mm:ss minus one second, plus an isZero output.

Test Plan:
1. Reset then code 1 with presetBCD=24'h0F9F7A -> timeBCD=24'h025959 next cycle, FSM LOADED, all flags low.
2. Load 24'h000003, code 3 for 1 cycle, then code 4 (TICK_DIV=4) -> decrements to 000002/000001/000000 at cycles 4/8/12 after start; expiredPulse exactly once at cycle 12; expired and timeBCD=0 held thereafter.
3. Load 24'h100000, run one tick -> 24'h095959; load 24'h010000, one tick -> 24'h005959.
4. Code 3 with timeBCD=0 from IDLE -> expired=1 and expiredPulse=1 the next cycle, with no secondTick.
5. Code 1 asserted in the cycle a tick would occur -> preset loaded, no decrement, running=0; code 0 in RUN -> timeBCD=0, IDLE.
6. resetN pulsed low mid-RUN asynchronously between edges -> outputs zero immediately; after release, no count until code 1 then code 3.
